alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operation request present.
REQ-005 SHALL have port: in_ready  output  1  stage can accept a request this cycle.
REQ-006 SHALL have port: aluop  input  3  ALU operation code from ALU control.
REQ-007 SHALL have port: src_a  input  WIDTH  first operand.
REQ-008 SHALL have port: src_b  input  WIDTH  second operand.
REQ-009 SHALL have port: out_valid  output  1  registered result present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 SHALL have port: result  output  WIDTH  registered ALU result.
REQ-012 SHALL have port: zero  output  1  result == 0, registered with result.
REQ-013 SHALL have port: ovf  output  1  signed overflow, add/sub only.
REQ-014 SHALL have port: illegal  output  1  aluop was the unassigned code 3'b110.
REQ-015 SHALL have port: op_count  output  16  count of results accepted by the consumer.

Function
REQ-016 SHALL decode aluop as: 000 add, 001 sub, 010 and, 011 or, 100 signed slt, 101 xor, 111 nop, 110 illegal.
REQ-017 SHALL compute add/sub modulo 2^WIDTH; ovf=1 iff operand signs make the signed result wrong (add: equal signs, result sign differs; sub: signs differ, result sign differs from src_a).
REQ-018 SHALL produce slt result 1 (zero-extended) iff $signed(src_a) < $signed(src_b), else 0; ovf=0.
REQ-019 SHALL produce result 0, ovf 0 for nop; result 0, ovf 0, illegal 1 for 110; illegal 0 for every other code.
REQ-020 SHALL set zero = (result == 0) for every op, including nop and illegal.
REQ-021 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, no skid).
REQ-022 SHALL capture a request when in_valid && in_ready: result/zero/ovf/illegal load, out_valid=1 next cycle (latency 1).
REQ-023 SHALL hold result, zero, ovf, illegal stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid after out_valid && out_ready unless a new request is captured in the same cycle.
REQ-025 SHALL, on simultaneous accept and capture, replace outputs with the new request with no bubble.
REQ-026 SHALL ignore aluop/src_a/src_b when no capture occurs.
REQ-027 SHALL increment op_count by 1 on each out_valid && out_ready cycle, wrapping 16'hFFFF -> 0.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, set out_valid=0, result=0, zero=0, ovf=0, illegal=0, op_count=0.
REQ-029 SHALL discard any held result and ignore in_valid in a reset cycle; in_ready is 1 in the cycle after reset.
REQ-030 SHALL give reset priority over capture and accept in the same cycle.

Verification
REQ-031 SHALL verify add: 7FFFFFFF+00000001 -> result 80000000, ovf 1, zero 0, out_valid one cycle after capture.
REQ-032 SHALL verify sub 5-5 -> result 0, zero 1, ovf 0; slt FFFFFFFF vs 00000001 -> result 1.
REQ-033 SHALL verify backpressure: out_ready=0 for 3 cycles after result 0000000A -> result held, in_ready=0, second request not captured until release.
REQ-034 SHALL verify streaming: in_valid and out_ready held 1 for 4 ops -> 4 back-to-back results, op_count 0 -> 4.
REQ-035 SHALL verify aluop 110 with operands 3/4 -> result 0, zero 1, illegal 1; next op add clears illegal.
REQ-036 SHALL verify rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid 0, op_count 0, in_ready 1.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: request/response bundle for the ALU execute stage.
//   Request  (master -> slave): in_valid, aluop, src_a, src_b; slave returns in_ready.
//   Response (slave -> master): out_valid, result, zero, ovf, illegal; master returns out_ready.
//   master modport: the producer/consumer side (testbench or pipeline neighbours).
//   slave modport:  the ALU stage itself.
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluop;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, aluop, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, aluop, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: single-register ALU execute stage with valid/ready on both sides.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : alu_exec_stage_if.slave (request in, registered result out)
//   op_count : 16-bit wrapping count of results taken by the consumer
// A request is captured when in_valid && in_ready; the result appears one cycle later and is
// held until out_ready. in_ready allows capture whenever the output register is empty or
// being drained in the same cycle, so streaming runs without bubbles.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_exec_stage_if.slave      bus,
  output logic [15:0]          op_count
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpSlt = 3'b100,
    OpXor = 3'b101,
    OpIll = 3'b110,
    OpNop = 3'b111
  } aluop_e;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      count_q, count_d;

  logic capture;
  logic accept;

  // Combinational ALU
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    sum     = bus.src_a + bus.src_b;
    diff    = bus.src_a - bus.src_b;
    unique case (aluop_e'(bus.aluop))
      OpAdd: begin
        alu_res = sum;
        // Same-sign operands whose sum flips sign
        alu_ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        // Opposite-sign operands whose difference loses src_a's sign
        alu_ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OpAnd: alu_res = bus.src_a & bus.src_b;
      OpOr:  alu_res = bus.src_a | bus.src_b;
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OpXor: alu_res = bus.src_a ^ bus.src_b;
      OpIll: alu_ill = 1'b1;
      OpNop: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;
  assign accept       = valid_q && bus.out_ready;

  // Next state: a capture in the same cycle as an accept overrides the clear
  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    count_d   = count_q + {15'd0, accept};
    if (accept) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      valid_d   = 1'b1;
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      ovf_d     = alu_ovf;
      illegal_d = alu_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;
  assign op_count      = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: table-driven vectors through a scoreboard, plus hand-written
// sequences for latency, streaming, backpressure, illegal op and reset-during-stall.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] op_count;

  alu_exec_stage_if #(.WIDTH(32)) bus ();

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: 33-bit sign-extended arithmetic for overflow detection
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    case (op)
      3'b000: begin s = {a[31], a} + {b[31], b}; e.result = s[31:0]; e.ovf = s[32] ^ s[31]; end
      3'b001: begin s = {a[31], a} - {b[31], b}; e.result = s[31:0]; e.ovf = s[32] ^ s[31]; end
      3'b010: e.result = a & b;
      3'b011: e.result = a | b;
      3'b100: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: e.result = a ^ b;
      3'b110: e.illegal = 1'b1;
      default: e.result = 32'd0;
    endcase
    return e;
  endfunction

  // One clock: drive at negedge, sample handshake 1 before posedge, score, then take the edge.
  task automatic cycle(input logic iv, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input exp_t e,
                       output logic cap, output logic acc);
    exp_t got;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.aluop     = op;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.out_ready = ordy;
    #4;
    cap = iv && bus.in_ready;
    acc = bus.out_valid && ordy;
    if (acc) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        got = sb_q.pop_front();
        check("result", bus.result, got.result);
        check("zero", {31'd0, bus.zero}, {31'd0, got.result == 32'd0});
        check("ovf", {31'd0, bus.ovf}, {31'd0, got.ovf});
        check("illegal", {31'd0, bus.illegal}, {31'd0, got.illegal});
      end
    end
    if (cap) sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic c, a;
    cycle(1'b0, 3'b111, 32'hDEAD_BEEF, 32'hCAFE_F00D, ordy, '0, c, a);
  endtask

  // Reset with in_valid high to show it is ignored
  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.aluop     = 3'b000;
    bus.src_a     = 32'h1;
    bus.src_b     = 32'h1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs[17];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        c, a;
    int          n_acc;
    logic [15:0] cnt0;
    exp_t        e;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};
    vecs[2]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6]  = '{3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{3'b001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0};
    vecs[8]  = '{3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[10] = '{3'b011, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0};
    vecs[11] = '{3'b101, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b0};
    vecs[13] = '{3'b110, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b0, 1'b1};
    vecs[14] = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[15] = '{3'b100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};
    vecs[16] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.aluop = 3'b000;
    bus.src_a = '0;
    bus.src_b = '0;
    do_reset();

    // Latency: add overflow case visible exactly one cycle after capture
    check("lat_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    cycle(1'b1, 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b0, '{32'h8000_0000, 1'b1, 1'b0}, c, a);
    #1;
    check("lat_captured", {31'd0, c}, 32'd1);
    check("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_result", bus.result, 32'h8000_0000);
    check("lat_ovf", {31'd0, bus.ovf}, 32'd1);
    check("lat_zero", {31'd0, bus.zero}, 32'd0);
    idle(1'b1);

    // Streaming: 4 back-to-back ops, op_count 0 -> 4
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      e = model(3'(i), 32'd10 + 32'(i), 32'd3);
      cycle(i < 4, 3'(i), 32'd10 + 32'(i), 32'd3, 1'b1, e, c, a);
      if (a) n_acc++;
      if (i >= 1) check("stream_accept", {31'd0, a}, 32'd1);
    end
    check("stream_n_acc", n_acc, 32'd4);
    #1;
    check("stream_op_count", {16'd0, op_count}, 32'd4);

    // Vector table, streamed
    cnt0 = op_count;
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1,
            '{vecs[i].res, vecs[i].ovf, vecs[i].ill}, c, a);
    end
    idle(1'b1);
    #1;
    check("table_op_count", {16'd0, op_count}, {16'd0, cnt0 + 16'd17});

    // Random vectors against the reference model, with random backpressure
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      cycle(1'b1, rop, ra, rb, 1'($urandom_range(0, 1)), model(rop, ra, rb), c, a);
    end
    idle(1'b1);
    idle(1'b1);

    // Backpressure: result 0000000A held 3 cycles, second request waits
    cycle(1'b1, 3'b000, 32'd4, 32'd6, 1'b1, '{32'h0000_000A, 1'b0, 1'b0}, c, a);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'b011, 32'd1, 32'd2, 1'b0, '{32'h3, 1'b0, 1'b0}, c, a);
      check("bp_no_capture", {31'd0, c}, 32'd0);
      #1;
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_held_result", bus.result, 32'h0000_000A);
      check("bp_held_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    cycle(1'b1, 3'b011, 32'd1, 32'd2, 1'b1, '{32'h3, 1'b0, 1'b0}, c, a);
    check("bp_release_capture", {31'd0, c}, 32'd1);
    check("bp_release_accept", {31'd0, a}, 32'd1);
    idle(1'b1);

    // Illegal opcode then add clears illegal
    cycle(1'b1, 3'b110, 32'd3, 32'd4, 1'b1, '{32'h0, 1'b0, 1'b1}, c, a);
    cycle(1'b1, 3'b000, 32'd3, 32'd4, 1'b1, '{32'h7, 1'b0, 1'b0}, c, a);
    idle(1'b1);
    check("sb_empty", sb_q.size(), 32'd0);

    // Reset while a held illegal result is stalled
    cycle(1'b1, 3'b110, 32'd3, 32'd4, 1'b0, '{32'h0, 1'b0, 1'b1}, c, a);
    idle(1'b0);
    #1;
    check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    check("stall_illegal", {31'd0, bus.illegal}, 32'd1);
    do_reset();
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    idle(1'b1);
    check("post_rst_idle_count", {16'd0, op_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
